// File: rtl/mux_na1_arb.sv
// mux_na1_arb: N-to-1 channel multiplexer with a single registered output
// stage. Mode 0 serves a fixed selector; mode 1 arbitrates round-robin among
// valid channels. Each capture is signalled by a one-hot ack.
module mux_na1_arb #(
  parameter int  CHANNELS = 4,
  parameter int  DATA_W   = 2,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mode,
  input  logic [SEL_W-1:0]           selector,
  input  logic [CHANNELS-1:0]        valid_in,
  input  logic [CHANNELS*DATA_W-1:0] data_in,
  input  logic                       ready_out,
  output logic [CHANNELS-1:0]        ack,
  output logic                       valid_out,
  output logic [DATA_W-1:0]          data_out,
  output logic [SEL_W-1:0]           chan_out,
  output logic                       sel_err
);

  // Selector space rounded up to a power of two so an out-of-range index
  // reads a constant-zero valid bit instead of running off the vector.
  localparam int NPOW = 1 << SEL_W;

  // Output stage and arbitration state
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SEL_W-1:0]  chan_q, chan_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic              sel_err_q, sel_err_d;

  // Arbitration intermediates
  logic              load;
  logic              sel_in_range;
  logic              fx_valid;
  logic              rr_valid;
  logic [SEL_W-1:0]  rr_idx;
  logic              grant_valid;
  logic [SEL_W-1:0]  grant_idx;
  logic [DATA_W-1:0] grant_data;
  logic [NPOW-1:0]   valid_ext;
  logic [DATA_W-1:0] chan_data [CHANNELS];
  logic [SEL_W-1:0]  rot_idx   [CHANNELS];
  logic [CHANNELS-1:0] rot_valid;

  // The stage can take a new word when empty or being drained this cycle.
  assign load         = !valid_q || ready_out;
  assign valid_ext    = NPOW'(valid_in);
  assign sel_in_range = ({1'b0, selector} < (SEL_W+1)'(CHANNELS));
  assign fx_valid     = sel_in_range && valid_ext[selector];

  // Unpack channel data and build the round-robin scan order starting at ptr.
  // ptr is always < CHANNELS, so one conditional subtract gives the modulo.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    logic [SEL_W:0] sum;
    assign chan_data[gi] = data_in[gi*DATA_W +: DATA_W];
    assign sum           = {1'b0, ptr_q} + (SEL_W+1)'(gi);
    assign rot_idx[gi]   = (sum >= (SEL_W+1)'(CHANNELS))
                         ? SEL_W'(sum - (SEL_W+1)'(CHANNELS))
                         : sum[SEL_W-1:0];
    assign rot_valid[gi] = valid_ext[rot_idx[gi]];
  end

  // Round-robin: the first valid channel in scan order (lowest offset) wins.
  always_comb begin
    rr_valid = 1'b0;
    rr_idx   = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (rot_valid[k]) begin
        rr_valid = 1'b1;
        rr_idx   = rot_idx[k];
      end
    end
  end

  // Pick the grant source by mode and mux out the granted channel's data.
  always_comb begin
    grant_valid = mode ? rr_valid : fx_valid;
    grant_idx   = mode ? rr_idx   : selector;
    grant_data  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (grant_idx == SEL_W'(k)) grant_data = chan_data[k];
    end
  end

  // One-hot ack: only when the stage loads, and never while in reset.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ack
    assign ack[gi] = !reset && load && grant_valid && (grant_idx == SEL_W'(gi));
  end

  // Next-state for the output stage, the rotation pointer and the error flag.
  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    chan_d    = chan_q;
    ptr_d     = ptr_q;
    sel_err_d = sel_err_q;
    if (load) begin
      valid_d = grant_valid;
      if (grant_valid) begin
        data_d = grant_data;
        chan_d = grant_idx;
      end
      if (mode && grant_valid) begin
        ptr_d = (grant_idx == SEL_W'(CHANNELS - 1)) ? '0 : grant_idx + SEL_W'(1);
      end
      if (!mode && !sel_in_range) begin
        sel_err_d = 1'b1;
      end
    end
  end

  // State registers; reset discards any in-flight word immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      data_q    <= '0;
      chan_q    <= '0;
      ptr_q     <= '0;
      sel_err_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      data_q    <= data_d;
      chan_q    <= chan_d;
      ptr_q     <= ptr_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign chan_out  = chan_q;
  assign sel_err   = sel_err_q;

endmodule
